uart_transmitter: RTL and testbench
===================================

Name: uart_transmitter

Overview:
- Serial transmitter for the UART link; its frame format is identical to what the UART receiver block expects.
- Frame: 1 start bit (low), 8 data bits LSB first, 1 parity bit, 1 stop bit (high).
- Accepts bytes over a valid/ready interface into a small internal FIFO and serialises them back-to-back on tx.
- Bit timing comes from an internal divider on the system clock, so no separate UART clock is required.

Parameters:
- CLKS_PER_BIT, 2, system clock cycles per serial bit; must be ≥1. Default 2 matches the UART clock at half the system clock.
- FIFO_DEPTH, 4, transmit FIFO entries; must be a power of 2, ≥2.
- PARITY_ODD, 1, 1 selects odd parity (parity bit = ~^data); 0 selects even parity (parity bit = ^data).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  8  byte to transmit.
- data_valid  input  1  data_in is valid this cycle.
- data_ready  output  1  FIFO can accept a byte. Combinational: !full && !reset.
- tx  output  1  serial line, registered, idles high.
- busy  output  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (sampled on clk edge): tx=1, busy=0, fifo_level=0, FIFO emptied, FSM=IDLE, bit counter=0, divider=0.
- Reset asserted mid-frame: the frame is aborted and tx returns high at that edge. Queued bytes are discarded and no partial resume occurs.
- Push: data_valid && data_ready at an edge writes data_in into the FIFO. data_valid while full is ignored, and the byte is lost by contract.
- Simultaneous push and pop in the same cycle are both performed; fifo_level is unchanged.
- Read and write pointers wrap modulo FIFO_DEPTH. fifo_level saturates at neither end; overflow and underflow are impossible by construction.
- FSM states: IDLE, START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT.
  - IDLE: tx=1. If FIFO non-empty: pop into the shift register, compute the parity bit from the popped byte, and go to START_BIT. The pop is a same-edge pop.
  - START_BIT: tx=0 for CLKS_PER_BIT cycles, then go to DATA_BITS with bit_count=0.
  - DATA_BITS: tx=shift[bit_count] for CLKS_PER_BIT cycles per bit. bit_count increments; after bit 7 go to PARITY_BIT.
  - PARITY_BIT: tx=parity bit for CLKS_PER_BIT cycles, then go to STOP_BIT.
  - STOP_BIT: tx=1 for CLKS_PER_BIT cycles. On the last cycle:
    - if the FIFO is non-empty, pop and go directly to START_BIT (no idle gap);
    - otherwise go to IDLE.
- Divider: counts 0..CLKS_PER_BIT-1 within each bit and resets on every bit transition. With CLKS_PER_BIT=1 every cycle is a bit boundary.
- Latency: byte pushed at edge k with the FIFO empty and FSM in IDLE:
  - it appears in the FIFO after edge k;
  - it is popped at edge k+1, and tx is low from edge k+1.
  - Frame length is exactly 11*CLKS_PER_BIT cycles.
- busy = (state != IDLE) || (fifo_level != 0), registered-equivalent. It drops in the cycle the FSM re-enters IDLE with an empty FIFO.
- tx is driven from a flop only; no combinational glitches.

Test Plan:
- Byte 0xA5, PARITY_OD D=1, CLKS_PER_BIT=2:
  - tx per bit: 0,1,0,1,0,0,1,0,1,1,1 (start, data 1 0 1 0 0 1 0 1, parity 1, stop).
  - Each bit lasts 2 cycles, 22 cycles total; busy then falls and tx stays 1.
- Byte 0x07, odd parity -> parity bit 0. Same byte with PARITY_ODD=0 -> parity bit 1. Also check a stop bit of 1 in both cases.
- Stream 0x10..0x17 with data_valid held and honouring data_ready:
  - data_ready deasserts when fifo_level=4;
  - all 8 bytes appear on tx in order with no idle cycles between stop and start;
  - total time from first start to last stop is 88*CLKS_PER_BIT cycles.
- Reset during DATA_BITS of 0x3C with 2 bytes queued:
  - tx=1 and fifo_level=0 after that edge;
  - no further start bit appears until a new push.
- CLKS_PER_BIT=1, push 0xFF: frame is 0,1×8,1 (odd parity of eight ones),1; 11 cycles long.
- Push while full (fifo_level=4, data_valid=1, data_ready=0): the byte is not stored, fifo_level stays 4, and the transmitted sequence excludes it.

Source files
------------

// File: rtl/uart_transmitter.sv
// UART transmitter: 8N-with-parity frames (start, 8 data LSB first, parity, stop)
// fed from a small FIFO, bit timing from an internal clock divider.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_ODD   = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    data_in,
  input  logic                          data_valid,
  output logic                          data_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {IDLE, START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT} state_t;

  state_t          state;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [DW-1:0]   div;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            parity;
  logic            full, empty, push, pop, bit_end;

  function automatic logic calc_parity(input logic [7:0] b);
    return (PARITY_ODD != 0) ? ~^b : ^b;
  endfunction

  assign full       = (fifo_level == LW'(FIFO_DEPTH));
  assign empty      = (fifo_level == '0);
  assign data_ready = !full && !reset;
  assign push       = data_valid && data_ready;
  assign bit_end    = (div == DW'(CLKS_PER_BIT - 1));
  // Pop from IDLE, or on the last stop-bit cycle so frames run back-to-back.
  assign pop        = !empty && (state == IDLE || (state == STOP_BIT && bit_end));
  assign busy       = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tx      <= 1'b1;
      div     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      parity  <= 1'b0;
    end else if (state == IDLE) begin
      tx  <= 1'b1;
      div <= '0;
      if (pop) begin
        shift  <= mem[rd_ptr];
        parity <= calc_parity(mem[rd_ptr]);
        state  <= START_BIT;
        tx     <= 1'b0;
      end
    end else if (!bit_end) begin
      div <= div + DW'(1);
    end else begin
      div <= '0;
      unique case (state)
        START_BIT: begin
          state   <= DATA_BITS;
          bit_cnt <= '0;
          tx      <= shift[0];
        end
        DATA_BITS: begin
          if (bit_cnt == 3'd7) begin
            state <= PARITY_BIT;
            tx    <= parity;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            tx      <= shift[bit_cnt + 3'd1];
          end
        end
        PARITY_BIT: begin
          state <= STOP_BIT;
          tx    <= 1'b1;
        end
        STOP_BIT: begin
          if (pop) begin
            shift  <= mem[rd_ptr];
            parity <= calc_parity(mem[rd_ptr]);
            state  <= START_BIT;
            tx     <= 1'b0;
          end else begin
            state <= IDLE;
            tx    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: three configurations share one stimulus stream
// and are checked each cycle against a frame-level model.
module tb_uart_transmitter;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       tx_o [3];
  logic       busy_o [3];
  logic       rdy_o [3];
  logic [2:0] lvl_o [3];

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  // dut0: 2 clk/bit odd, dut1: 1 clk/bit odd, dut2: 2 clk/bit even
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int C = (g == 1) ? 1 : 2;
    localparam int O = (g == 2) ? 0 : 1;
    uart_transmitter #(.CLKS_PER_BIT(C), .FIFO_DEPTH(4), .PARITY_ODD(O)) u_dut (
      .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
      .data_ready(rdy_o[g]), .tx(tx_o[g]), .busy(busy_o[g]), .fifo_level(lvl_o[g]));
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cpb(input int i);
    return (i == 1) ? 1 : 2;
  endfunction

  // Frame as a bit vector, bit n is the n-th bit on the line.
  function automatic logic [10:0] build_frame(input logic [7:0] b, input bit odd);
    logic p;
    p = ($countones(b) % 2 == 1) ? !odd : odd;
    return {1'b1, p, b, 1'b0};
  endfunction

  // Model: queue of pending bytes, plus the active frame and elapsed cycles in it.
  logic [7:0]  mf [3][4];
  int          mcnt [3];
  int          mt [3];
  bit          mact [3];
  logic [10:0] mfr [3];

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      bit rdy;
      rdy = (mcnt[i] < 4);
      if (reset) begin
        mcnt[i] = 0;
        mact[i] = 0;
        mt[i]   = 0;
      end else begin
        if (mact[i]) begin
          mt[i]++;
          if (mt[i] == 11 * cpb(i)) mact[i] = 0;
        end
        if (!mact[i] && mcnt[i] > 0) begin
          mfr[i] = build_frame(mf[i][0], i != 2);
          for (int k = 0; k < 3; k++) mf[i][k] = mf[i][k+1];
          mcnt[i]--;
          mact[i] = 1;
          mt[i]   = 0;
        end
        if (data_valid && rdy) begin
          mf[i][mcnt[i]] = data_in;
          mcnt[i]++;
        end
      end
    end
  endtask

  function automatic int exp_tx(input int i);
    return mact[i] ? int'(mfr[i][mt[i] / cpb(i)]) : 1;
  endfunction

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("tx[%0d]", i), int'(tx_o[i]), exp_tx(i));
        chk($sformatf("busy[%0d]", i), int'(busy_o[i]), int'(mact[i] || mcnt[i] != 0));
        chk($sformatf("level[%0d]", i), int'(lvl_o[i]), mcnt[i]);
        chk($sformatf("ready[%0d]", i), int'(rdy_o[i]), int'(!reset && mcnt[i] < 4));
      end
    end
  end

  // Stream timing monitor on dut0: cycles from first start bit until busy drops.
  bit mon_en = 0;
  bit started = 0;
  int span = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (!started && !tx_o[0]) started = 1;
      if (started && busy_o[0]) span++;
    end
  end

  logic cap_tx [3][24];
  logic cap_busy [3][24];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy_o[0] || busy_o[1] || busy_o[2]) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("idle_timeout", 1, 0);
    tick();
  endtask

  task automatic run_byte(input logic [7:0] b);
    wait_idle();
    data_in    = b;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    @(negedge clk);
    chk("queued_level", int'(lvl_o[0]), 1);
    chk("queued_tx_idle", int'(tx_o[0]), 1);
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        cap_tx[g][j]   = tx_o[g];
        cap_busy[g][j] = busy_o[g];
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [10:0] a5_exp;
    logic [7:0]  b;
    bit          r, saw_full;
    int          lows;

    @(posedge clk);
    chk_en = 1;
    @(negedge clk);
    chk("reset_ready", int'(rdy_o[0]), 0);
    chk("reset_tx", int'(tx_o[0]), 1);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", int'(rdy_o[0]), 1);
    chk("post_reset_level", int'(lvl_o[0]), 0);
    chk("post_reset_busy", int'(busy_o[0]), 0);

    // Model pins
    a5_exp = 11'b111_0100_1010;
    chk("model_a5_frame", int'(build_frame(8'hA5, 1'b1)), int'(a5_exp));
    chk("model_07_odd_par", int'(build_frame(8'h07, 1'b1) >> 9) & 1, 0);
    chk("model_07_even_par", int'(build_frame(8'h07, 1'b0) >> 9) & 1, 1);

    // 0xA5 on dut0: 11 bits of 2 cycles each, then idle
    run_byte(8'hA5);
    for (int j = 0; j < 22; j++) chk($sformatf("a5_bit%0d", j), int'(cap_tx[0][j]), int'(a5_exp[j/2]));
    chk("a5_after_tx", int'(cap_tx[0][22]), 1);
    chk("a5_after_busy", int'(cap_busy[0][22]), 0);
    chk("a5_last_busy", int'(cap_busy[0][21]), 1);

    // 0x07: parity bit (samples 18,19) differs between odd and even configs
    run_byte(8'h07);
    chk("07_odd_parity", int'(cap_tx[0][18]), 0);
    chk("07_even_parity", int'(cap_tx[2][18]), 1);
    chk("07_odd_stop", int'(cap_tx[0][20]), 1);
    chk("07_even_stop", int'(cap_tx[2][20]), 1);

    // 0xFF on 1 clk/bit: 0, eight 1s, parity 1, stop 1, 11 cycles
    run_byte(8'hFF);
    chk("ff_start", int'(cap_tx[1][0]), 0);
    for (int j = 1; j < 11; j++) chk($sformatf("ff_bit%0d", j), int'(cap_tx[1][j]), 1);
    chk("ff_busy_last", int'(cap_busy[1][10]), 1);
    chk("ff_busy_done", int'(cap_busy[1][11]), 0);

    // Stream 0x10..0x17 honouring dut0 ready
    wait_idle();
    mon_en = 1; started = 0; span = 0; saw_full = 0;
    b = 8'h10;
    for (int n = 0; n < 600 && b <= 8'h17; n++) begin
      data_in    = b;
      data_valid = 1'b1;
      @(negedge clk);
      r = rdy_o[0];
      if (!r && lvl_o[0] == 3'd4) saw_full = 1;
      tick();
      if (r) b++;
    end
    data_valid = 1'b0;
    chk("stream_all_pushed", int'(b), 8'h18);
    wait_idle();
    mon_en = 0;
    chk("stream_saw_full", int'(saw_full), 1);
    chk("stream_span", span, 176);

    // Push while full is dropped
    wait_idle();
    data_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      data_in = 8'($urandom_range(0, 8'hED));
      tick();
      @(negedge clk);
      if (lvl_o[0] == 3'd4) break;
    end
    data_in = 8'hEE;
    chk("full_level", int'(lvl_o[0]), 4);
    chk("full_not_ready", int'(rdy_o[0]), 0);
    tick();
    data_valid = 1'b0;
    @(negedge clk);
    chk("full_level_kept", int'(lvl_o[0]), 4);

    // Reset mid-frame (data bits of 0x3C) with two bytes queued
    wait_idle();
    data_valid = 1'b1;
    data_in = 8'h3C; tick();
    data_in = 8'h11; tick();
    data_in = 8'h22; tick();
    data_valid = 1'b0;
    @(negedge clk);
    chk("reset_queue_level", int'(lvl_o[0]), 2);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_tx", int'(tx_o[0]), 1);
    chk("midreset_level", int'(lvl_o[0]), 0);
    lows = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (!tx_o[0]) lows++;
    end
    chk("midreset_no_restart", lows, 0);

    // Random traffic with occasional resets
    tick();
    for (int n = 0; n < 3000; n++) begin
      data_in    = 8'($urandom);
      data_valid = ($urandom_range(0, 2) != 0);
      reset      = ($urandom_range(0, 399) == 0);
      tick();
    end
    reset = 1'b0;
    data_valid = 1'b0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
